// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, action decode and operand packing helpers for the D->E stage register.
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int          EXC_NONE     = 0;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] FLUSH_PC_DEF = 32'h0000_4180;

    typedef enum logic [1:0] {ACT_LOAD, ACT_STALL, ACT_HOLD, ACT_FLUSH} act_e;

    // Strict priority: flush > hold > stall > load.
    function automatic act_e act_of(input logic flush, input logic hold, input logic stall);
        return flush ? ACT_FLUSH : hold ? ACT_HOLD : stall ? ACT_STALL : ACT_LOAD;
    endfunction

    function automatic int a_off(input int k, input int raddr_w);
        return k * raddr_w;
    endfunction

    function automatic int v_off(input int k, input int data_w);
        return k * data_w;
    endfunction
endpackage

// File: rtl/e_stage_reg_p_if.sv
// e_stage_reg_p_if: D-side bundle, control events and E-side bundle of the D->E register.
//   master: drives stall/hold/flush and D_*, observes E_* and stall_cnt.
//   slave : the stage register itself.
interface e_stage_reg_p_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_SRC = 2,
    parameter int EXC_W   = 5,
    parameter int CNT_W   = 16
);
    logic                       stall;
    logic                       hold;
    logic                       flush;
    logic                       D_valid;
    logic [DATA_W-1:0]          D_instr;
    logic [NUM_SRC*RADDR_W-1:0] D_A;
    logic [NUM_SRC*DATA_W-1:0]  D_V;
    logic [RADDR_W-1:0]         D_A3;
    logic [DATA_W-1:0]          D_pc;
    logic [DATA_W-1:0]          D_E32;
    logic                       D_bd;
    logic [EXC_W-1:0]           D_exc;
    logic                       E_valid;
    logic [DATA_W-1:0]          E_instr;
    logic [NUM_SRC*RADDR_W-1:0] E_A;
    logic [NUM_SRC*DATA_W-1:0]  E_V;
    logic [RADDR_W-1:0]         E_A3;
    logic [DATA_W-1:0]          E_pc;
    logic [DATA_W-1:0]          E_pc8;
    logic [DATA_W-1:0]          E_E32;
    logic                       E_bd;
    logic [EXC_W-1:0]           E_exc;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output stall, hold, flush, D_valid, D_instr, D_A, D_V, D_A3, D_pc, D_E32, D_bd, D_exc,
        input  E_valid, E_instr, E_A, E_V, E_A3, E_pc, E_pc8, E_E32, E_bd, E_exc, stall_cnt
    );
    modport slave (
        input  stall, hold, flush, D_valid, D_instr, D_A, D_V, D_A3, D_pc, D_E32, D_bd, D_exc,
        output E_valid, E_instr, E_A, E_V, E_A3, E_pc, E_pc8, E_E32, E_bd, E_exc, stall_cnt
    );
endinterface

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: one pipeline field register with async active-low reset, clear-to-value, load and hold.
//   clk, reset (active-low async), i_clr (load i_clr_val, wins), i_ld (load i_d), o_q (held otherwise).
module pipe_field_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_ld,
    input  logic         i_clr,
    input  logic [W-1:0] i_clr_val,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_q <= RST_VAL;
        else if (i_clr) r_q <= i_clr_val;
        else if (i_ld) r_q <= i_d;

    assign o_q = r_q;
endmodule

// File: rtl/e_stage_reg_p.sv
// e_stage_reg_p: parametrised D->E pipeline register with flush/hold/stall control and a saturating stall counter.
//   clk, reset (active-low async), bus (slave modport: D_* in, control in, E_* and stall_cnt out).
module e_stage_reg_p
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                RADDR_W  = 5,
    parameter int                NUM_SRC  = 2,
    parameter int                EXC_W    = 5,
    parameter int                CNT_W    = 16,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(RESET_PC_DEF),
    parameter logic [DATA_W-1:0] FLUSH_PC = DATA_W'(FLUSH_PC_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    e_stage_reg_p_if.slave bus
);
    act_e                       w_act;
    logic                       w_flush;
    logic                       w_load;
    logic                       w_bubble;
    logic                       w_capture_pc;
    logic [NUM_SRC*RADDR_W-1:0] w_e_a;
    logic [NUM_SRC*DATA_W-1:0]  w_e_v;
    logic [CNT_W-1:0]           r_stall_cnt;

    assign w_act        = act_of(bus.flush, bus.hold, bus.stall);
    assign w_flush      = w_act == ACT_FLUSH;
    assign w_load       = w_act == ACT_LOAD;
    assign w_bubble     = w_flush || w_act == ACT_STALL;
    // pc and bd survive a stall bubble so CP0 still sees the stalled instruction's pc.
    assign w_capture_pc = w_load || w_act == ACT_STALL;

    pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val(1'b0),
        .i_d(bus.D_valid), .o_q(bus.E_valid)
    );

    // Invalid instructions enter as NOP with A3=0 so nothing downstream writes or forwards.
    pipe_field_reg #(.W(DATA_W), .RST_VAL('0)) u_instr (
        .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val(DATA_W'(NOP_INSTR)),
        .i_d(bus.D_valid ? bus.D_instr : DATA_W'(NOP_INSTR)), .o_q(bus.E_instr)
    );

    pipe_field_reg #(.W(RADDR_W), .RST_VAL('0)) u_a3 (
        .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val('0),
        .i_d(bus.D_valid ? bus.D_A3 : '0), .o_q(bus.E_A3)
    );

    pipe_field_reg #(.W(DATA_W), .RST_VAL('0)) u_e32 (
        .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val('0),
        .i_d(bus.D_E32), .o_q(bus.E_E32)
    );

    pipe_field_reg #(.W(EXC_W), .RST_VAL(EXC_W'(EXC_NONE))) u_exc (
        .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val(EXC_W'(EXC_NONE)),
        .i_d(bus.D_exc), .o_q(bus.E_exc)
    );

    pipe_field_reg #(.W(1), .RST_VAL(1'b0)) u_bd (
        .clk(clk), .reset(reset), .i_ld(w_capture_pc), .i_clr(w_flush), .i_clr_val(1'b0),
        .i_d(bus.D_bd), .o_q(bus.E_bd)
    );

    pipe_field_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .i_ld(w_capture_pc), .i_clr(w_flush), .i_clr_val(FLUSH_PC),
        .i_d(bus.D_pc), .o_q(bus.E_pc)
    );

    // pc+8 is registered alongside pc so E never carries an adder on its output.
    pipe_field_reg #(.W(DATA_W), .RST_VAL(RESET_PC + DATA_W'(8))) u_pc8 (
        .clk(clk), .reset(reset), .i_ld(w_capture_pc), .i_clr(w_flush),
        .i_clr_val(FLUSH_PC + DATA_W'(8)), .i_d(bus.D_pc + DATA_W'(8)), .o_q(bus.E_pc8)
    );

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        pipe_field_reg #(.W(RADDR_W), .RST_VAL('0)) u_a (
            .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val('0),
            .i_d(bus.D_A[a_off(k, RADDR_W) +: RADDR_W]), .o_q(w_e_a[a_off(k, RADDR_W) +: RADDR_W])
        );
        pipe_field_reg #(.W(DATA_W), .RST_VAL('0)) u_v (
            .clk(clk), .reset(reset), .i_ld(w_load), .i_clr(w_bubble), .i_clr_val('0),
            .i_d(bus.D_V[v_off(k, DATA_W) +: DATA_W]), .o_q(w_e_v[v_off(k, DATA_W) +: DATA_W])
        );
    end

    assign bus.E_A = w_e_a;
    assign bus.E_V = w_e_v;

    // Counts effective stall edges only; saturates instead of wrapping.
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_stall_cnt <= '0;
        else if (w_act == ACT_STALL && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;

    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_e_stage_reg_p.sv
// tb_e_stage_reg_p: scoreboard bench driving a 2-channel and a 3-channel/2-bit-counter stage in lockstep.
module tb_e_stage_reg_p;
    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    e_stage_reg_p_if #(.NUM_SRC(2))             bus2 ();
    e_stage_reg_p_if #(.NUM_SRC(3), .CNT_W(2)) bus3 ();

    e_stage_reg_p #(.NUM_SRC(2))             u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    e_stage_reg_p #(.NUM_SRC(3), .CNT_W(2)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [14:0] a;
        logic [95:0] v;
        logic [4:0]  a3;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] e32;
        logic        bd;
        logic [4:0]  exc;
        int          stalls;
    } exp_t;

    exp_t m;
    exp_t e;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return n > mx ? mx : n;
    endfunction

    task automatic model_reset;
        m = '{valid: 1'b0, instr: '0, a: '0, v: '0, a3: '0, pc: 32'h0000_3000, pc8: 32'h0000_3008,
              e32: '0, bd: 1'b0, exc: '0, stalls: 0};
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_valid2"}, 96'(bus2.E_valid), 96'(0));
        chk({t, "_pc2"},    96'(bus2.E_pc),    96'(32'h3000));
        chk({t, "_pc8_2"},  96'(bus2.E_pc8),   96'(32'h3008));
        chk({t, "_cnt2"},   96'(bus2.stall_cnt), 96'(0));
        chk({t, "_instr2"}, 96'(bus2.E_instr), 96'(0));
        chk({t, "_valid3"}, 96'(bus3.E_valid), 96'(0));
        chk({t, "_pc3"},    96'(bus3.E_pc),    96'(32'h3000));
        chk({t, "_pc8_3"},  96'(bus3.E_pc8),   96'(32'h3008));
        chk({t, "_cnt3"},   96'(bus3.stall_cnt), 96'(0));
        chk({t, "_v3"},     96'(bus3.E_V),     96'(0));
    endtask

    // Apply one cycle of stimulus at a falling edge and predict E after the next rising edge.
    task automatic step(input bit fl, input bit ho, input bit st, input bit dv,
                        input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] e32,
                        input logic [14:0] a, input logic [95:0] v, input logic [4:0] a3,
                        input bit bd, input logic [4:0] exc);
        bus2.flush = fl; bus2.hold = ho; bus2.stall = st; bus2.D_valid = dv;
        bus2.D_instr = instr; bus2.D_pc = pc; bus2.D_E32 = e32; bus2.D_A = a[9:0];
        bus2.D_V = v[63:0]; bus2.D_A3 = a3; bus2.D_bd = bd; bus2.D_exc = exc;
        bus3.flush = fl; bus3.hold = ho; bus3.stall = st; bus3.D_valid = dv;
        bus3.D_instr = instr; bus3.D_pc = pc; bus3.D_E32 = e32; bus3.D_A = a;
        bus3.D_V = v; bus3.D_A3 = a3; bus3.D_bd = bd; bus3.D_exc = exc;
        if (fl) begin
            m.valid = 1'b0; m.instr = '0; m.a = '0; m.v = '0; m.a3 = '0;
            m.e32 = '0; m.bd = 1'b0; m.exc = '0; m.pc = 32'h0000_4180;
        end else if (!ho) begin
            if (st) begin
                m.valid = 1'b0; m.instr = '0; m.a = '0; m.v = '0; m.a3 = '0; m.e32 = '0; m.exc = '0;
                m.stalls++;
            end else begin
                m.valid = dv; m.instr = instr; m.a = a; m.v = v; m.a3 = a3; m.e32 = e32; m.exc = exc;
            end
            m.pc = pc;
            m.bd = bd;
        end
        if (!m.valid) begin
            m.instr = '0;
            m.a3 = '0;
        end
        m.pc8 = m.pc + 32'd8;
        sb_q.push_back(m);
        @(negedge clk);
    endtask

    task automatic rnd_step;
        step($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             1'($urandom), $urandom, $urandom, $urandom, 15'($urandom),
             {$urandom, $urandom, $urandom}, 5'($urandom), 1'($urandom), 5'($urandom));
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("valid2", 96'(bus2.E_valid),   96'(e.valid));
            chk("instr2", 96'(bus2.E_instr),   96'(e.instr));
            chk("A2",     96'(bus2.E_A),       96'(e.a[9:0]));
            chk("V2",     96'(bus2.E_V),       96'(e.v[63:0]));
            chk("A3_2",   96'(bus2.E_A3),      96'(e.a3));
            chk("pc2",    96'(bus2.E_pc),      96'(e.pc));
            chk("pc8_2",  96'(bus2.E_pc8),     96'(e.pc8));
            chk("E32_2",  96'(bus2.E_E32),     96'(e.e32));
            chk("bd2",    96'(bus2.E_bd),      96'(e.bd));
            chk("exc2",   96'(bus2.E_exc),     96'(e.exc));
            chk("cnt2",   96'(bus2.stall_cnt), 96'(sat(e.stalls, 65535)));
            chk("valid3", 96'(bus3.E_valid),   96'(e.valid));
            chk("instr3", 96'(bus3.E_instr),   96'(e.instr));
            chk("A3ch",   96'(bus3.E_A),       96'(e.a));
            chk("V3ch",   bus3.E_V,            e.v);
            chk("A3_3",   96'(bus3.E_A3),      96'(e.a3));
            chk("pc3",    96'(bus3.E_pc),      96'(e.pc));
            chk("pc8_3",  96'(bus3.E_pc8),     96'(e.pc8));
            chk("E32_3",  96'(bus3.E_E32),     96'(e.e32));
            chk("bd3",    96'(bus3.E_bd),      96'(e.bd));
            chk("exc3",   96'(bus3.E_exc),     96'(e.exc));
            chk("cnt3",   96'(bus3.stall_cnt), 96'(sat(e.stalls, 3)));
        end
    end

    initial begin
        model_reset;
        @(negedge clk);
        chk_reset("rst0");
        reset = 1'b1;
        step(N, N, N, Y, 32'h8C22_0004, 32'h0000_3010, 32'h0000_0004, {5'd3, 5'd2, 5'd1},
             {32'h0000_0009, 32'h0000_0005, 32'h0000_0007}, 5'd2, N, 5'd0);
        repeat (3) step(N, N, Y, Y, 32'h0000_1234, 32'h0000_3024, 32'h0000_0055, 15'h1234,
                        96'h1, 5'd7, Y, 5'd3);
        step(N, N, N, Y, 32'h8C22_0004, 32'h0000_3010, 32'h0000_0004, {5'd3, 5'd2, 5'd1},
             {32'h0000_0009, 32'h0000_0005, 32'h0000_0007}, 5'd2, N, 5'd0);
        for (int i = 0; i < 4; i++)
            step(N, Y, Y, Y, $urandom, 32'h0000_3100 + 32'(i * 4), $urandom, 15'($urandom),
                 {$urandom, $urandom, $urandom}, 5'($urandom), Y, 5'($urandom));
        step(N, N, N, Y, 32'h0043_0820, 32'h0000_3014, 32'h0000_0010, {5'd6, 5'd5, 5'd4},
             {32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 5'd1, N, 5'd0);
        step(Y, Y, Y, Y, 32'hDEAD_BEEF, 32'h0000_3018, 32'h0000_0077, 15'h7FFF,
             {3{32'hFFFF_FFFF}}, 5'd31, Y, 5'd4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_reset("rst_async");
        model_reset;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) step(N, N, Y, Y, 32'h0000_2222, 32'h0000_3030, 32'h0000_0001, 15'h0421,
                        96'h2, 5'd9, N, 5'd1);
        step(N, N, N, Y, 32'hAC43_0008, 32'hFFFF_FFFC, 32'hFFFF_FFF8, {5'd17, 5'd2, 5'd1},
             {32'hCAFE_BABE, 32'h0000_0005, 32'h0000_0007}, 5'd3, Y, 5'd0);
        step(N, N, N, N, 32'h1111_1111, 32'h0000_3040, 32'h0000_0001, 15'h1111,
             96'h3, 5'd8, N, 5'd2);
        repeat (400) rnd_step;
        @(posedge clk);
        #3;
        chk("sb_drain", 96'(sb_q.size()), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
